// File: rtl/taxi_mii_phy_rx_gen.sv
// PHY-side MII receive generator: serialises AXI-stream byte frames into preamble/SFD
// followed by low-nibble-first MII RX nibbles, then holds the line idle for the inter-frame gap.
module taxi_mii_phy_rx_gen #(
    parameter int PRE_BYTES  = 8,
    parameter int IFG_CYCLES = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    input  logic       s_axis_tlast,
    input  logic       s_axis_tuser,
    output logic [3:0] mii_rxd,
    output logic       mii_rx_dv,
    output logic       mii_rx_er,
    output logic       stat_frame,
    output logic       stat_underflow,
    output logic       busy
);

    localparam int IFG_W = $clog2(IFG_CYCLES + 1);
    localparam logic [4:0] PRE_LAST = 5'(2 * PRE_BYTES - 1);
    localparam logic [IFG_W-1:0] IFG_LAST = IFG_W'(IFG_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_DROP,
        ST_IFG
    } state_t;

    state_t           state;
    logic [4:0]       pre_cnt;
    logic [IFG_W-1:0] ifg_cnt;
    logic             phase;
    logic [3:0]       hi_nib;
    logic             last_reg;
    logic             user_reg;
    logic             do_load;
    logic             do_uf;

    // A byte moves only on a cycle where s_axis_tvalid and s_axis_tready are both high at the
    // clock edge; tready depends on state (and never on tvalid), and is held low during reset.
    always_comb begin
        s_axis_tready = 1'b0;
        case (state)
            ST_IDLE:     s_axis_tready = (PRE_BYTES == 0);
            ST_PREAMBLE: s_axis_tready = (pre_cnt == PRE_LAST);
            ST_DATA:     s_axis_tready = phase && !last_reg;
            ST_DROP:     s_axis_tready = 1'b1;
            default:     s_axis_tready = 1'b0;
        endcase
        if (rst) s_axis_tready = 1'b0;
    end

    // Every point that asks for a byte either loads one or, if the source is empty, underflows.
    always_comb begin
        do_load = s_axis_tvalid && s_axis_tready && (state != ST_DROP);
        do_uf   = !s_axis_tvalid &&
                  (((state == ST_PREAMBLE) && (pre_cnt == PRE_LAST)) ||
                   ((state == ST_DATA) && phase && !last_reg));
    end

    assign busy = (state != ST_IDLE);

    // MII outputs are loaded on the transition into the state they belong to, so the
    // first preamble nibble appears one cycle after tvalid is seen in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            pre_cnt        <= '0;
            ifg_cnt        <= '0;
            phase          <= 1'b0;
            hi_nib         <= '0;
            last_reg       <= 1'b0;
            user_reg       <= 1'b0;
            mii_rxd        <= '0;
            mii_rx_dv      <= 1'b0;
            mii_rx_er      <= 1'b0;
            stat_frame     <= 1'b0;
            stat_underflow <= 1'b0;
        end else begin
            stat_frame     <= 1'b0;
            stat_underflow <= 1'b0;
            if (do_load) begin
                state     <= ST_DATA;
                phase     <= 1'b0;
                hi_nib    <= s_axis_tdata[7:4];
                last_reg  <= s_axis_tlast;
                user_reg  <= s_axis_tuser;
                mii_rxd   <= s_axis_tdata[3:0];
                mii_rx_dv <= 1'b1;
                mii_rx_er <= s_axis_tuser;
            end else if (do_uf) begin
                state          <= ST_DROP;
                mii_rxd        <= 4'h0;
                mii_rx_dv      <= 1'b1;
                mii_rx_er      <= 1'b1;
                stat_underflow <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        mii_rxd   <= 4'h0;
                        mii_rx_dv <= 1'b0;
                        mii_rx_er <= 1'b0;
                        if (s_axis_tvalid) begin
                            state     <= ST_PREAMBLE;
                            pre_cnt   <= '0;
                            mii_rxd   <= 4'h5;
                            mii_rx_dv <= 1'b1;
                        end
                    end
                    ST_PREAMBLE: begin
                        pre_cnt   <= pre_cnt + 5'd1;
                        mii_rxd   <= (pre_cnt + 5'd1 == PRE_LAST) ? 4'hD : 4'h5;
                        mii_rx_dv <= 1'b1;
                        mii_rx_er <= 1'b0;
                    end
                    ST_DATA: begin
                        if (!phase) begin
                            phase     <= 1'b1;
                            mii_rxd   <= hi_nib;
                            mii_rx_er <= user_reg;
                        end else begin
                            // Only the last byte reaches here; others load or underflow.
                            state      <= ST_IFG;
                            ifg_cnt    <= '0;
                            stat_frame <= 1'b1;
                            mii_rxd    <= 4'h0;
                            mii_rx_dv  <= 1'b0;
                            mii_rx_er  <= 1'b0;
                        end
                    end
                    ST_DROP: begin
                        mii_rxd   <= 4'h0;
                        mii_rx_dv <= 1'b0;
                        mii_rx_er <= 1'b0;
                        if (s_axis_tvalid && s_axis_tlast) begin
                            state   <= ST_IFG;
                            ifg_cnt <= '0;
                        end
                    end
                    ST_IFG: begin
                        mii_rxd   <= 4'h0;
                        mii_rx_dv <= 1'b0;
                        mii_rx_er <= 1'b0;
                        if (ifg_cnt == IFG_LAST) begin
                            state <= ST_IDLE;
                        end else begin
                            ifg_cnt <= ifg_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state     <= ST_IDLE;
                        mii_rxd   <= 4'h0;
                        mii_rx_dv <= 1'b0;
                        mii_rx_er <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
